// File: rtl/i2s_adc_receiver.sv
// i2s_adc_receiver
// Captures the codec ADC I2S stream in the CLOCK_50 domain. BCLK, LRCK and
// ADCDAT are oversampled through synchronisers. Each stereo pair is assembled
// from one LRCK period and presented on a valid/ready interface. Pairs that
// arrive while the consumer is stalled are dropped and counted.

`timescale 1ns / 1ps

module i2s_adc_receiver #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int SYNC_STAGES  = 2,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      ena_i,
  input  logic                      bclk_i,
  input  logic                      lrck_i,
  input  logic                      adcdat_i,
  output logic [2*SAMPLE_WIDTH-1:0] samp_data_o,
  output logic                      samp_val_o,
  input  logic                      samp_rdy_i,
  output logic                      overrun_o,
  output logic                      short_err_o,
  output logic [CNT_WIDTH-1:0]      ovr_cnt_o,
  input  logic                      clear_ovr_i
);

  // Bit counter wide enough to index one slot.
  localparam int BW = (SAMPLE_WIDTH > 1) ? $clog2(SAMPLE_WIDTH) : 1;
  localparam logic [BW-1:0]        LAST_BIT = BW'(SAMPLE_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  // Capture FSM encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;  // waiting for the start of a left slot
  localparam logic [1:0] ST_SKIP  = 2'd1;  // dropping the first BCLK rise of a slot
  localparam logic [1:0] ST_SHIFT = 2'd2;  // shifting in SAMPLE_WIDTH bits
  localparam logic [1:0] ST_WAIT  = 2'd3;  // ignoring trailing bits until the next LRCK edge

  localparam logic CH_L = 1'b0;
  localparam logic CH_R = 1'b1;

  // ---------------------------------------------------------------------------
  // Synchronisers and edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] bclk_sync;
  logic [SYNC_STAGES-1:0] lrck_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   bclk_hist;
  logic                   lrck_hist;

  logic bclk_s;
  logic lrck_s;
  logic dat_s;
  logic bclk_rise;
  logic lrck_rise;
  logic lrck_fall;
  logic lrck_edge;

  // Bring the three codec lines into clk_i and keep one cycle of history.
  // All three chains have the same depth, so BCLK, LRCK and data keep their
  // relative alignment after synchronisation.
  always_ff @(posedge clk_i) begin
    // NOTE: reset is synchronous, so it is tested inside the clocked block
    // and is not listed in the sensitivity list.
    if (!rst_n_i) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      dat_sync  <= '0;
      bclk_hist <= 1'b0;
      lrck_hist <= 1'b0;
    end else begin
      // NOTE: registers take non-blocking assignments. Each stage then
      // samples the value its neighbour held before this edge, which is
      // what keeps the shift chain a chain.
      bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], bclk_i};
      lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], lrck_i};
      dat_sync  <= {dat_sync[SYNC_STAGES-2:0], adcdat_i};
      bclk_hist <= bclk_sync[SYNC_STAGES-1];
      lrck_hist <= lrck_sync[SYNC_STAGES-1];
    end
  end

  assign bclk_s    = bclk_sync[SYNC_STAGES-1];
  assign lrck_s    = lrck_sync[SYNC_STAGES-1];
  assign dat_s     = dat_sync[SYNC_STAGES-1];
  assign bclk_rise = bclk_s & ~bclk_hist;
  assign lrck_rise = lrck_s & ~lrck_hist;
  assign lrck_fall = ~lrck_s & lrck_hist;
  assign lrck_edge = lrck_s ^ lrck_hist;

  // ---------------------------------------------------------------------------
  // Frame capture FSM
  // ---------------------------------------------------------------------------
  logic [1:0]              state_q;
  logic [1:0]              state_d;
  logic                    ch_q;
  logic                    ch_d;
  logic [BW-1:0]           bitcnt_q;
  logic [SAMPLE_WIDTH-1:0] shreg_q;
  logic [SAMPLE_WIDTH-1:0] shreg_nxt;
  logic [SAMPLE_WIDTH-1:0] left_q;
  logic                    commit_q;

  logic bit_clr;
  logic shift_en;
  logic word_done;
  logic short_det;

  assign shreg_nxt = {shreg_q[SAMPLE_WIDTH-2:0], dat_s};

  // Next-state and control decode. Any LRCK edge that lands mid-shift means
  // the slot was too short, so the frame is abandoned. A falling edge is
  // still a valid left-slot start, so capture resumes from there.
  always_comb begin
    // NOTE: every output of this block gets a default first. A path that
    // leaves one unassigned would infer a latch.
    state_d   = state_q;
    ch_d      = ch_q;
    bit_clr   = 1'b0;
    shift_en  = 1'b0;
    word_done = 1'b0;
    short_det = 1'b0;

    if (!ena_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (lrck_fall) begin
            state_d = ST_SKIP;
            ch_d    = CH_L;
          end
        end

        ST_SKIP: begin
          if (bclk_rise) begin
            state_d = ST_SHIFT;
            bit_clr = 1'b1;
          end
        end

        ST_SHIFT: begin
          if (lrck_edge) begin
            short_det = 1'b1;
            if (lrck_fall) begin
              state_d = ST_SKIP;
              ch_d    = CH_L;
            end else begin
              state_d = ST_IDLE;
            end
          end else if (bclk_rise) begin
            shift_en = 1'b1;
            if (bitcnt_q == LAST_BIT) begin
              word_done = 1'b1;
              state_d   = ST_WAIT;
            end
          end
        end

        ST_WAIT: begin
          if (ch_q == CH_L && lrck_rise) begin
            state_d = ST_SKIP;
            ch_d    = CH_R;
          end else if (ch_q == CH_R && lrck_fall) begin
            state_d = ST_SKIP;
            ch_d    = CH_L;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM state, bit counter, shift register and the stored left sample.
  // The right sample stays in shreg_q until the commit cycle. shreg_q only
  // moves in SHIFT, so it is stable during that one-cycle gap.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      ch_q     <= CH_L;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      left_q   <= '0;
      commit_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;

      if (bit_clr) begin
        bitcnt_q <= '0;
      end else if (shift_en) begin
        bitcnt_q <= bitcnt_q + 1'b1;
      end

      if (shift_en) begin
        shreg_q <= shreg_nxt;
      end

      if (word_done && ch_q == CH_L) begin
        left_q <= shreg_nxt;
      end

      // A right word only completes after this frame's left word was stored,
      // so left_q and shreg_q always belong to the same LRCK period.
      commit_q <= word_done && (ch_q == CH_R);
    end
  end

  // ---------------------------------------------------------------------------
  // Output holding register, handshake and overrun accounting
  // ---------------------------------------------------------------------------
  logic drop;

  // A pair is dropped only if the previous one is still waiting and is not
  // being taken in this same cycle.
  assign drop = commit_q && samp_val_o && !samp_rdy_i;

  // Load committed pairs, retire transferred ones and flag drops.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      samp_data_o <= '0;
      samp_val_o  <= 1'b0;
      overrun_o   <= 1'b0;
      short_err_o <= 1'b0;
    end else begin
      overrun_o   <= drop;
      short_err_o <= short_det;

      if (commit_q && !drop) begin
        samp_data_o <= {left_q, shreg_q};
        samp_val_o  <= 1'b1;
      end else if (samp_rdy_i) begin
        samp_val_o  <= 1'b0;
      end
    end
  end

  // Saturating drop counter. A clear takes priority over a same-cycle drop.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ovr_cnt_o <= '0;
    end else if (clear_ovr_i) begin
      ovr_cnt_o <= '0;
    end else if (drop && ovr_cnt_o != CNT_MAX) begin
      ovr_cnt_o <= ovr_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_i2s_adc_receiver.sv
// tb_i2s_adc_receiver
// Drives a behavioural I2S codec into i2s_adc_receiver. Pairs expected from
// complete frames are queued and compared as the DUT hands them over.

`timescale 1ns / 1ps

module tb_i2s_adc_receiver;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b0;
  logic          bclk = 1'b0;
  logic          lrck = 1'b1;
  logic          adcdat = 1'b0;
  logic [2*W-1:0] samp_data;
  logic          samp_val;
  logic          samp_rdy = 1'b1;
  logic          overrun;
  logic          short_err;
  logic [7:0]    ovr_cnt;
  logic          clear_ovr = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int ovr_pulses = 0;
  int short_pulses = 0;
  int lat_mode = 0;

  logic [2*W-1:0] exp_q[$];
  event last_rise_ev;

  typedef struct {
    logic [W-1:0]   left;
    logic [W-1:0]   right;
    logic [2*W-1:0] exp_pair;
  } vec_t;

  vec_t vecs[6];

  i2s_adc_receiver #(
    .SAMPLE_WIDTH(W),
    .SYNC_STAGES (2),
    .CNT_WIDTH   (8)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .ena_i      (ena),
    .bclk_i     (bclk),
    .lrck_i     (lrck),
    .adcdat_i   (adcdat),
    .samp_data_o(samp_data),
    .samp_val_o (samp_val),
    .samp_rdy_i (samp_rdy),
    .overrun_o  (overrun),
    .short_err_o(short_err),
    .ovr_cnt_o  (ovr_cnt),
    .clear_ovr_i(clear_ovr)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic int half_period(input bit jit);
    return 100 + (jit ? int'($urandom_range(19, 0)) : 0);
  endfunction

  // One I2S frame. Each slot begins with an LRCK change on a BCLK fall. The
  // first rise after it carries no data, and the MSB is on the second rise.
  // ena_ctl: 1 = raise ena at the start of the right slot,
  //          2 = drop ena after five left bits have been clocked.
  task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r,
                            input int slot, input int left_len,
                            input bit jit, input int ena_ctl);
    logic [W-1:0] s;
    int len;
    @(posedge clk);
    #3.5;
    for (int ch = 0; ch < 2; ch++) begin
      s   = (ch == 0) ? l : r;
      len = (ch == 0) ? left_len : slot;
      for (int k = 0; k < len; k++) begin
        lrck   = (ch == 1);
        adcdat = (k >= 1 && k <= W) ? s[4'(W - k)] : 1'b0;
        if (ena_ctl == 1 && ch == 1 && k == 0) ena = 1'b1;
        if (ena_ctl == 2 && ch == 0 && k == 6) ena = 1'b0;
        #(half_period(jit));
        bclk = 1'b1;
        if (ch == 1 && k == W) -> last_rise_ev;
        #(half_period(jit));
        bclk = 1'b0;
      end
    end
    adcdat = 1'b0;
  endtask

  // Scoreboard: compare every handed-over pair with the oldest expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (overrun) ovr_pulses++;
      if (short_err) short_pulses++;
      if (samp_val && samp_rdy) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_pair: got %0h, required no pair", samp_data);
        end else begin
          check("pair", samp_data, exp_q.pop_front());
        end
      end
    end
  end

  // Timed checks anchored on the last right-bit BCLK rise.
  always begin
    @(last_rise_ev);
    if (lat_mode == 1) begin
      repeat (3) @(posedge clk);
      #1 check("latency_early", samp_val, 1'b0);
      @(posedge clk);
      #1 check("latency_val", samp_val, 1'b1);
    end else if (lat_mode == 2) begin
      repeat (3) @(posedge clk);
      #1 clear_ovr = 1'b1;
      @(posedge clk);
      #1 clear_ovr = 1'b0;
      check("overrun_with_clear", overrun, 1'b1);
      check("clear_beats_incr", ovr_cnt, 8'd0);
    end
  end

  initial begin
    logic [W-1:0] rl;
    logic [W-1:0] rr;

    vecs[0] = '{16'hA5C3, 16'h3C5A, 32'hA5C3_3C5A};
    vecs[1] = '{16'h0000, 16'hFFFF, 32'h0000_FFFF};
    vecs[2] = '{16'h8000, 16'h0001, 32'h8000_0001};
    vecs[3] = '{16'hFFFF, 16'h0000, 32'hFFFF_0000};
    vecs[4] = '{16'h1234, 16'hFEDC, 32'h1234_FEDC};
    vecs[5] = '{16'hA5C3, 16'h3C5A, 32'hA5C3_3C5A};

    // Reset state.
    repeat (4) @(posedge clk);
    #1;
    check("rst_data", samp_data, 32'h0);
    check("rst_val", samp_val, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_short", short_err, 1'b0);
    check("rst_cnt", ovr_cnt, 8'd0);
    rst_n = 1'b1;
    ena   = 1'b1;
    repeat (10) @(posedge clk);

    // Table of 64-BCLK frames with the consumer always ready.
    for (int i = 0; i < 6; i++) begin
      lat_mode = (i < 2) ? 1 : 0;
      exp_q.push_back(vecs[i].exp_pair);
      send_frame(vecs[i].left, vecs[i].right, 32, 32, 1'b0, 0);
    end
    lat_mode = 0;

    // Consumer stalled for three frames: the first pair is held, two are dropped.
    @(posedge clk);
    #1 samp_rdy = 1'b0;
    exp_q.push_back(32'h1111_2222);
    send_frame(16'h1111, 16'h2222, 32, 32, 1'b0, 0);
    send_frame(16'h3333, 16'h4444, 32, 32, 1'b0, 0);
    send_frame(16'h5555, 16'h6666, 32, 32, 1'b0, 0);
    check("held_val", samp_val, 1'b1);
    check("held_data", samp_data, 32'h1111_2222);
    check("overrun_pulses", ovr_pulses, 2);
    check("ovr_cnt_two", ovr_cnt, 8'd2);
    @(posedge clk);
    #1 samp_rdy = 1'b1;
    repeat (4) @(posedge clk);
    #1 check("val_after_take", samp_val, 1'b0);

    // A further drop coincides with a counter clear.
    samp_rdy = 1'b0;
    exp_q.push_back(32'h7777_8888);
    send_frame(16'h7777, 16'h8888, 32, 32, 1'b0, 0);
    lat_mode = 2;
    send_frame(16'h9999, 16'hAAAA, 32, 32, 1'b0, 0);
    lat_mode = 0;
    check("overrun_pulses_3", ovr_pulses, 3);
    @(posedge clk);
    #1 samp_rdy = 1'b1;
    repeat (4) @(posedge clk);

    // Enabled during a right slot: nothing until the next full frame.
    #1 ena = 1'b0;
    send_frame(16'hDEAD, 16'hBEEF, 32, 32, 1'b0, 1);
    exp_q.push_back(32'hC0DE_F00D);
    send_frame(16'hC0DE, 16'hF00D, 32, 32, 1'b0, 0);

    // Left slot truncated after ten bits.
    send_frame(16'hBAD0, 16'hBAD1, 32, 11, 1'b0, 0);
    check("short_once", short_pulses, 1);
    exp_q.push_back(32'h5A5A_A5A5);
    send_frame(16'h5A5A, 16'hA5A5, 32, 32, 1'b0, 0);

    // Enable dropped mid-left-shift with a pair pending, then a one-cycle reset.
    @(posedge clk);
    #1 samp_rdy = 1'b0;
    exp_q.push_back(32'h0F0F_F0F0);
    send_frame(16'h0F0F, 16'hF0F0, 32, 32, 1'b0, 0);
    send_frame(16'h1357, 16'h2468, 32, 32, 1'b0, 2);
    repeat (8) @(posedge clk);
    #1;
    check("pending_val", samp_val, 1'b1);
    check("pending_data", samp_data, 32'h0F0F_F0F0);
    check("no_drop_when_disabled", ovr_pulses, 3);
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("rst2_data", samp_data, 32'h0);
    check("rst2_val", samp_val, 1'b0);
    check("rst2_overrun", overrun, 1'b0);
    check("rst2_short", short_err, 1'b0);
    check("rst2_cnt", ovr_cnt, 8'd0);
    rst_n    = 1'b1;
    ena      = 1'b1;
    samp_rdy = 1'b1;
    repeat (10) @(posedge clk);

    // Random data with BCLK phase and jitter swept against clk.
    for (int i = 0; i < 60; i++) begin
      rl = 16'($urandom);
      rr = 16'($urandom);
      exp_q.push_back({rl, rr});
      send_frame(rl, rr, 20, 20, 1'b1, 0);
    end

    repeat (20) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("short_total", short_pulses, 1);
    check("overrun_total", ovr_pulses, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
